dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
Multi-cycle data-memory access controller that sits directly downstream of the ALU in the MIPS datapath. It replaces the zero-latency data memory path for load and store instructions. The ALU result acts as the byte address, and the register-file second read port supplies store data. It drives a variable-latency word-wide SRAM port and stalls the core until the access completes. It also handles byte, halfword and word lanes, sign/zero extension, misalignment detection and bus timeout.

Parameters:
ADDR_W, 8, word-address width on the memory side (memory depth = 2**ADDR_W words)
TIMEOUT, 15, max cycles waiting for mem_ready before the access is aborted (1..255)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
req_read  input  1  load request (MemRead)
req_write  input  1  store request (MemWrite); wins if both are asserted
addr  input  32  byte address (ula_result)
wdata  input  32  store data (ReadData2)
size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
sign_ext  input  1  1 = sign-extend byte/half loads, 0 = zero-extend
rdata  output  32  formatted load data, valid in DONE
stall  output  1  hold PC and register writes while high
misaligned  output  1  one-cycle pulse on an unaligned request; no access issued
bus_error  output  1  one-cycle pulse (in DONE) when the access timed out
mem_req  output  1  memory request, held until mem_ready or timeout
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  word address = addr[ADDR_W+1:2]
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read data, sampled when mem_ready=1
mem_ready  input  1  access complete; may already be high in the first BUSY cycle

Behaviour:
- Reset (sync, active-high): state=IDLE, timeout counter=0, and all outputs 0, including rdata. A reset during BUSY drops mem_req on the next edge, with no completion and no error pulse.
- FSM states are IDLE, BUSY and DONE.
- Alignment check: a request is misaligned if size=01 and addr[0]=1, or if size=1x and addr[1:0]!=0.
- IDLE, aligned request present:
  - stall=1 combinationally in the same cycle.
  - Latch we, mem_addr, mem_be, mem_wdata, the lane offset, size and sign_ext.
  - Next state is BUSY.
- IDLE, misaligned request:
  - misaligned=1 for one cycle, stall=0, no memory access.
  - State stays IDLE.
- IDLE, no request: stall=0, mem_req=0.
- BUSY:
  - mem_req=1, stall=1, with mem_* held stable from the latch.
  - The counter increments each cycle.
  - If mem_ready=1: a load captures formatted mem_rdata into rdata; next state is DONE.
  - If the counter reaches TIMEOUT without mem_ready: rdata=0, bus_error=1 registered for the DONE cycle; next state is DONE.
- DONE:
  - stall=0 and mem_req=0 for exactly one cycle, so the core commits the instruction.
  - Request inputs are ignored in DONE because they belong to the completing instruction.
  - Next state is IDLE.
  - rdata holds its value until the next load completes.
- Latency: an aligned access with mem_ready in the first BUSY cycle stalls for 2 cycles (IDLE, BUSY) and completes in DONE. Each extra wait cycle adds one.
- Store formatting:
  - Byte: mem_wdata = {4{wdata[7:0]}}, mem_be = 0001<<addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}, mem_be = 0011 if addr[1]=0, else 1100.
  - Word: mem_wdata = wdata, mem_be = 1111.
- Loads drive mem_be=1111 and mem_we=0.
- Load formatting:
  - Byte: select lane addr[1:0], then extend bit 7 or zeros.
  - Half: select the half addr[1], then extend bit 15 or zeros.
  - Word: pass through.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo memory size.

Decomposition:
- Shared package/header holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings ST_IDLE, ST_BUSY, ST_DONE;
  - the default TIMEOUT.
- One natural combinational sub-module, lane_fmt, does store lane replication/byte enables and load extraction/extension. It is reused by both directions of the controller.

Test Plan:
1. Word store, addr=0x0000_0010, wdata=0xDEADBEEF, mem_ready high in first BUSY cycle -> mem_addr=4, mem_be=1111, mem_we=1, stall high 2 cycles, DONE stall=0.
2. Byte load, addr=0x13, sign_ext=1, mem_rdata=0x80FF_1234 -> mem_be=1111, rdata=0xFFFF_FF80. Repeat with sign_ext=0 -> rdata=0x0000_0080.
3. Half store, addr=0x6, wdata=0x0000_ABCD, mem_ready delayed 3 cycles -> mem_be=1100, mem_wdata=0xABCD_ABCD stable throughout BUSY, stall high 5 cycles.
4. Half load at addr=0x5 -> misaligned pulse 1 cycle, stall=0, mem_req never asserted, state stays IDLE.
5. Load with mem_ready never asserted, TIMEOUT=15 -> mem_req high 15 cycles, then DONE with bus_error=1, rdata=0, stall=0.
6. Reset asserted in second BUSY cycle of a store -> next cycle mem_req=0, stall=0, all outputs 0. A following word load at 0x20 completes normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared encodings, default timeout and alignment helper for the data-memory controller
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Reserved size 2'b11 behaves as a word, so any size with bit 1 set needs word alignment
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return sz[1] ? (off != 2'b00) : (sz[0] & off[0]);
    endfunction

endpackage

// File: rtl/dmem_ctrl_lane_fmt.sv
// dmem_ctrl_lane_fmt: store lane replication/byte enables and load lane extraction with sign/zero extension
module dmem_ctrl_lane_fmt
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = mem_rdata[{off, 3'b000} +: 8];
        half_v   = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        st_wdata = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        st_be    = size == SZ_BYTE ? 4'b0001 << off
                 : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        ld_data  = size == SZ_BYTE ? {{24{sign_ext & byte_v[7]}}, byte_v}
                 : size == SZ_HALF ? {{16{sign_ext & half_v[15]}}, half_v} : mem_rdata;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle load/store controller between the ALU and a variable-latency word-wide SRAM
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic        we_q, sext_q;
    logic [1:0]  off_q, size_q;
    logic        req, mis, go, busy, tmo;
    logic [1:0]  f_size, f_off;
    logic        f_sext;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;
    logic        unused_hi;

    assign req       = req_read | req_write;
    assign mis       = is_misaligned(size, addr[1:0]);
    assign busy      = state == ST_BUSY;
    assign go        = state == ST_IDLE && req && !mis;
    assign tmo       = busy && !mem_ready && cnt == 8'(TIMEOUT - 1);
    assign unused_hi = ^addr[31:ADDR_W+2];

    // One formatter serves both directions: live request in IDLE, latched lane while BUSY
    assign f_size = state == ST_IDLE ? size : size_q;
    assign f_off  = state == ST_IDLE ? addr[1:0] : off_q;
    assign f_sext = state == ST_IDLE ? sign_ext : sext_q;

    dmem_ctrl_lane_fmt u_fmt (
        .size      (f_size),
        .off       (f_off),
        .sign_ext  (f_sext),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state == ST_IDLE ? (go ? ST_BUSY : ST_IDLE)
                   : busy ? ((mem_ready || tmo) ? ST_DONE : ST_BUSY) : ST_IDLE;
        stall      = go | busy;
        misaligned = state == ST_IDLE && req && mis;
        mem_req    = busy;
        mem_we     = busy & we_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= tmo;
            cnt       <= go ? 8'd0 : busy ? cnt + 8'd1 : cnt;
            if (go) begin
                we_q      <= req_write;
                sext_q    <= sign_ext;
                off_q     <= addr[1:0];
                size_q    <= size;
                mem_addr  <= addr[ADDR_W+1:2];
                mem_be    <= req_write ? st_be : 4'b1111;
                mem_wdata <= st_wdata;
            end
            // Stores leave rdata alone unless they time out
            if (busy && ((mem_ready && !we_q) || tmo))
                rdata <= tmo ? '0 : ld_data;
        end
    end

endmodule
